// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit for the execute stage: tracks in-flight destination
// registers after EX, selects the youngest ready producer per source, and stalls on hazards.
module fwd_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic                       ex_valid,
    input  logic                       ex_kill,
    input  logic                       ex_we,
    input  logic [4:0]                 ex_rd,
    input  logic [SEL_W-1:0]           ex_avail,
    input  logic [NUM_SRC*5-1:0]       ex_src,
    input  logic [NUM_SRC*XLEN-1:0]    rf_data,
    input  logic [DEPTH*XLEN-1:0]      stage_data,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic [NUM_SRC*XLEN-1:0]    fwd_data,
    output logic                       stall,
    output logic [31:0]                stall_cnt
);

    logic [DEPTH-1:0] ent_v;
    logic [4:0]       ent_rd    [DEPTH];
    logic [SEL_W-1:0] ent_avail [DEPTH];

    logic [NUM_SRC-1:0] found;
    logic [NUM_SRC-1:0] blocked;
    logic               push;

    // Lowest-index match is the youngest producer; older matches are shadowed.
    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        found    = '0;
        blocked  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_data[i*XLEN +: XLEN] = rf_data[i*XLEN +: XLEN];
            for (int k = 0; k < DEPTH; k++) begin
                if (!found[i] && ent_v[k] && (ent_rd[k] == ex_src[i*5 +: 5]) &&
                    (ex_src[i*5 +: 5] != 5'd0)) begin
                    found[i]                   = 1'b1;
                    fwd_sel[i*SEL_W +: SEL_W]  = SEL_W'(k + 1);
                    fwd_data[i*XLEN +: XLEN]   = stage_data[k*XLEN +: XLEN];
                    blocked[i]                 = (SEL_W'(k) < ent_avail[k]);
                end
            end
        end
    end

    assign stall = ex_valid & ~ex_kill & (|blocked);
    assign push  = ex_valid & ~ex_kill & ex_we & (ex_rd != 5'd0) & ~stall;

    // A stalled EX instruction is not recorded; a bubble enters entry 0 instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v     <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_rd[k]    <= '0;
                ent_avail[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                ent_v[k]     <= ent_v[k-1];
                ent_rd[k]    <= ent_rd[k-1];
                ent_avail[k] <= ent_avail[k-1];
            end
            ent_v[0]     <= push;
            ent_rd[0]    <= ex_rd;
            ent_avail[0] <= ex_avail;
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the execute stage of the pipelined core. It keeps a registered scoreboard of the destination registers still in flight between EX and register-file commit. For each source operand of the instruction in EX it selects the youngest in-flight producer or falls back to the register file. When that producer's data is not yet available (for example load-use), it asserts a stall and inserts a bubble into the scoreboard itself. It also counts stall cycles for performance monitoring.

## Interface
- XLEN, 32, datapath width
- NUM_SRC, 2, source operands checked per EX instruction
- DEPTH, 2, tracked stages after EX (entry 0 = MEM, entry DEPTH-1 = WB)
- SEL_W, $clog2(DEPTH+1), derived; width of each select and avail field
- Reset is asynchronous, active-low (rst_n); single clock clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  whole-pipeline freeze (memory wait); scoreboard does not shift
- ex_valid  in  1  EX holds a real instruction
- ex_kill  in  1  EX instruction squashed; it is never recorded
- ex_we  in  1  EX instruction writes rd
- ex_rd  in  5  EX destination register
- ex_avail  in  SEL_W  first entry index whose stage_data holds the result (0 = ALU, 1 = load)
- ex_src  in  NUM_SRC*5  source register numbers; slice i at [i*5 +: 5]
- rf_data  in  NUM_SRC*XLEN  register-file read values, slice i
- stage_data  in  DEPTH*XLEN  result value currently in entry k's stage, slice k
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k+1 = entry k
- fwd_data  out  NUM_SRC*XLEN  selected operand value
- stall  out  1  EX must hold; bubble inserted after EX
- stall_cnt  out  32  saturating count of stall cycles

## Operation
- Scoreboard entry k holds {v, rd, avail}. Entry k matches source s when v=1, rd=s, and s≠0.
- The producer for source i is the lowest-index matching entry (youngest wins). If no entry matches, fwd_sel=0 and fwd_data=rf_data[i].
- A matching entry k is ready when k ≥ avail:
  - Ready: fwd_sel=k+1, fwd_data=stage_data[k].
  - Not ready: source i is blocked; fwd_sel/fwd_data still show that entry, and the values are don't-care.
- stall = ex_valid & ~ex_kill & (any source blocked). Source x0 never blocks and always reads rf_data, which the regfile guarantees is 0.
- Shift rule on each clk edge with hold=0:
  - Entry k+1 ← entry k.
  - Entry 0 ← {1, ex_rd, ex_avail} if ex_valid & ~ex_kill & ex_we & ex_rd≠0 & ~stall; otherwise entry 0 becomes invalid (bubble).
  - Entry DEPTH-1 is dropped, because its regfile write completes at that edge.
- hold=1: entries and stall_cnt are unchanged. Outputs keep being evaluated combinationally from current state.
- stall_cnt increments on each edge with stall=1 & hold=0. It saturates at 0xFFFF_FFFF.
- ex_avail ≥ DEPTH is illegal; the bench asserts it never occurs.

## Timing
- fwd_sel, fwd_data and stall are combinational from inputs and entries. There is no added latency.
- Scoreboard update takes effect 1 cycle after the edge.
- A load-use pair (load avail=1, consumer immediately behind) stalls exactly 1 cycle. On the next cycle it forwards from entry 1 (WB).
- An ALU-to-use pair forwards from entry 0 with no stall.
- A producer 2 instructions older forwards from entry 1 at DEPTH=2. A producer 3 or more older reads the regfile.
- Reset, asynchronous on rst_n falling edge:
  - All entries invalid and stall_cnt=0.
  - As a consequence, fwd_sel=0, fwd_data=rf_data, stall=0.
  - A reset mid-stall discards all in-flight entries.
- Simultaneous stall and hold: no shift and no count. stall stays asserted.
- ex_kill while blocked: stall drops the same cycle, and a bubble enters entry 0.

## Test plan
- Reset: drive rst_n=0 mid-run with valid entries → fwd_sel=0, stall=0, stall_cnt=0 immediately. Only after release does ADD x3 forward from the register file.
- ALU chain: ADD x5 (avail 0), then SUB rs1=x5 → SUB sees fwd_sel[0]=1, fwd_data=stage_data[0], stall=0.
- Load-use: LW x7 (avail 1), then ADD rs2=x7 → stall=1 for one cycle with entry 0 bubbled, then fwd_sel[1]=2 (WB), stall=0, stall_cnt=1.
- Youngest wins: ADD x4 → 5, ADD x4 → 9, then use x4 → fwd_sel=1, value 9. x0 cases: LW x0, then use x0 → no stall, fwd_sel=0.
- Hold: assert hold 3 cycles during a load-use stall → entries frozen, stall=1 throughout, stall_cnt unchanged. After release, counting resumes.
- Saturation and parameters: preload stall_cnt near max (force) → it stops at 0xFFFF_FFFF. Rerun all scenarios at DEPTH=4, NUM_SRC=3 with ex_avail=3 → 3 stall cycles.
